// File: rtl/alarm_frame_rx.sv
// Receive-side checker/decoder for the 8-byte "A mm:ss F CR" alarm status line.
// Fields are staged in shadow registers and published only when a whole frame is accepted.
module alarm_frame_rx #(
    parameter int TO_W        = 24,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_rdy,
    input  logic [7:0] rx_data,
    output logic [3:0] o_AMtens,
    output logic [3:0] o_AMones,
    output logic [3:0] o_AStens,
    output logic [3:0] o_ASones,
    output logic [3:0] o_dsp,
    output logic       o_alarm_en,
    output logic       o_trig,
    output logic       o_frame_vld,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        HUNT, P_MTENS, P_MONES, P_SEP, P_STENS, P_SONES, P_FLAG, P_CR
    } pos_t;

    pos_t            pos_reg, pos_next;
    logic [3:0]      mt_reg, mo_reg, st_reg, so_reg, dsp_reg;
    logic            colon_reg, en_reg, trig_reg;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            byte_ok, is_digit, is_alarm_flag, timeout, reject, accept_cr;

    function automatic logic digit_le(input logic [7:0] b, input logic [3:0] hi);
        return (b >= CH_ZERO) && (b <= (CH_ZERO + {4'd0, hi}));
    endfunction

    always_comb begin
        byte_ok       = 1'b0;
        is_digit      = 1'b0;
        is_alarm_flag = (rx_data == CH_T) || (rx_data == CH_AT);
        case (pos_reg)
            HUNT:    byte_ok = (rx_data == CH_A);
            P_MTENS: begin is_digit = digit_le(rx_data, 4'd5); byte_ok = is_digit || (rx_data == CH_DASH); end
            P_MONES: begin is_digit = digit_le(rx_data, 4'd9); byte_ok = is_digit || (rx_data == CH_DASH); end
            P_SEP:   byte_ok = (rx_data == CH_COLON) || (rx_data == CH_DASH);
            P_STENS: begin is_digit = digit_le(rx_data, 4'd5); byte_ok = is_digit || (rx_data == CH_DASH); end
            P_SONES: begin is_digit = digit_le(rx_data, 4'd9); byte_ok = is_digit || (rx_data == CH_DASH); end
            // Cross-field consistency is resolved here, once all fields are known
            P_FLAG: begin
                if (is_alarm_flag)
                    byte_ok = (dsp_reg == 4'b1111) && colon_reg;
                else if (rx_data == CH_DASH)
                    byte_ok = (colon_reg == dsp_reg[2]);
            end
            P_CR:    byte_ok = (rx_data == CH_CR);
            default: byte_ok = 1'b0;
        endcase

        // A strobe always beats an expiring timeout
        timeout   = !rx_data_rdy && (pos_reg != HUNT) && (to_cnt_reg == TO_LAST);
        reject    = rx_data_rdy && (pos_reg != HUNT) && !byte_ok;
        accept_cr = rx_data_rdy && (pos_reg == P_CR) && byte_ok;

        pos_next = pos_reg;
        if (timeout)
            pos_next = HUNT;
        else if (rx_data_rdy) begin
            if (byte_ok)
                pos_next = (pos_reg == P_CR) ? HUNT : pos_t'(pos_reg + 3'd1);
            else if (pos_reg != HUNT)
                pos_next = (rx_data == CH_A) ? P_MTENS : HUNT;
        end

        if (rx_data_rdy || (pos_reg == HUNT) || timeout)
            to_cnt_next = '0;
        else
            to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg     <= HUNT;
            to_cnt_reg  <= '0;
            mt_reg      <= 4'd0;
            mo_reg      <= 4'd0;
            st_reg      <= 4'd0;
            so_reg      <= 4'd0;
            dsp_reg     <= 4'd0;
            colon_reg   <= 1'b0;
            en_reg      <= 1'b0;
            trig_reg    <= 1'b0;
            o_AMtens    <= 4'd0;
            o_AMones    <= 4'd0;
            o_AStens    <= 4'd0;
            o_ASones    <= 4'd0;
            o_dsp       <= 4'd0;
            o_alarm_en  <= 1'b0;
            o_trig      <= 1'b0;
            o_frame_vld <= 1'b0;
            o_err       <= 1'b0;
            o_err_cnt   <= 8'd0;
        end else begin
            pos_reg     <= pos_next;
            to_cnt_reg  <= to_cnt_next;
            o_frame_vld <= accept_cr;
            o_err       <= reject || timeout;
            if ((reject || timeout) && (o_err_cnt != 8'hFF))
                o_err_cnt <= o_err_cnt + 8'd1;
            if (rx_data_rdy && byte_ok) begin
                case (pos_reg)
                    P_MTENS: begin mt_reg <= is_digit ? rx_data[3:0] : 4'd0; dsp_reg[3] <= is_digit; end
                    P_MONES: begin mo_reg <= is_digit ? rx_data[3:0] : 4'd0; dsp_reg[2] <= is_digit; end
                    P_SEP:   colon_reg <= (rx_data == CH_COLON);
                    P_STENS: begin st_reg <= is_digit ? rx_data[3:0] : 4'd0; dsp_reg[1] <= is_digit; end
                    P_SONES: begin so_reg <= is_digit ? rx_data[3:0] : 4'd0; dsp_reg[0] <= is_digit; end
                    P_FLAG: begin
                        en_reg   <= is_alarm_flag;
                        trig_reg <= (rx_data == CH_T);
                    end
                    P_CR: begin
                        o_AMtens   <= mt_reg;
                        o_AMones   <= mo_reg;
                        o_AStens   <= st_reg;
                        o_ASones   <= so_reg;
                        o_dsp      <= dsp_reg;
                        o_alarm_en <= en_reg;
                        o_trig     <= trig_reg;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_frame_rx.sv
// Bench for alarm_frame_rx: frame table, timeout/saturation/reset sequences, and
// random traffic, all checked each cycle against a buffer-based frame model.
module tb_alarm_frame_rx;
    localparam int TO = 50;
    localparam logic [7:0] CR = 8'h0D;
    localparam int NT = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_data_rdy;
    logic [7:0] rx_data;
    logic [3:0] o_AMtens, o_AMones, o_AStens, o_ASones, o_dsp;
    logic       o_alarm_en, o_trig, o_frame_vld, o_err;
    logic [7:0] o_err_cnt;

    alarm_frame_rx #(.TO_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data_rdy(rx_data_rdy), .rx_data(rx_data),
        .o_AMtens(o_AMtens), .o_AMones(o_AMones), .o_AStens(o_AStens), .o_ASones(o_ASones),
        .o_dsp(o_dsp), .o_alarm_en(o_alarm_en), .o_trig(o_trig),
        .o_frame_vld(o_frame_vld), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           errs;
        bit           ok;
        logic [3:0]   mt, mo, st, so, dsp;
        bit           en, trig;
    } fvec_t;

    fvec_t tbl [NT];
    int n_vec = 0, n_bad = 0;
    int vld_seen, err_seen, err_total;

    // Reference model: bytes of the frame in progress, judged as a string prefix
    logic [7:0] fb [0:7];
    int         flen, idle, m_cnt;
    logic [3:0] m_mt, m_mo, m_st, m_so, m_dsp;
    logic       m_en, m_trig, m_vld, m_err;

    function automatic bit dig(input logic [7:0] c, input int hi);
        return (int'(c) >= 48) && (int'(c) <= 48 + hi);
    endfunction

    function automatic bit field_ok(input int i, input logic [7:0] c);
        case (i)
            1, 4:    return (c == "-") || dig(c, 5);
            2, 5:    return (c == "-") || dig(c, 9);
            3:       return (c == ":") || (c == "-");
            6:       return (c == "T") || (c == "@") || (c == "-");
            7:       return c == CR;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit prefix_ok();
        bit all_dig, colon;
        for (int i = 1; i < flen; i++)
            if (!field_ok(i, fb[i])) return 1'b0;
        if (flen >= 7) begin
            all_dig = dig(fb[1], 9) && dig(fb[2], 9) && dig(fb[4], 9) && dig(fb[5], 9);
            colon   = (fb[3] == ":");
            if (fb[6] == "-") return colon == dig(fb[2], 9);
            return all_dig && colon;
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] val(input logic [7:0] c);
        return dig(c, 9) ? 4'(int'(c) - 48) : 4'd0;
    endfunction

    task automatic model_reset();
        flen = 0; idle = 0; m_cnt = 0;
        m_mt = 0; m_mo = 0; m_st = 0; m_so = 0; m_dsp = 0;
        m_en = 0; m_trig = 0; m_vld = 0; m_err = 0;
    endtask

    task automatic model_fail();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
        flen = 0;
    endtask

    task automatic model_step(input logic rdy, input logic [7:0] d);
        m_vld = 1'b0;
        m_err = 1'b0;
        if (rdy) begin
            idle = 0;
            if (flen == 0) begin
                if (d == "A") begin fb[0] = d; flen = 1; end
            end else begin
                fb[flen] = d;
                flen++;
                if (!prefix_ok()) begin
                    model_fail();
                    if (d == "A") begin fb[0] = d; flen = 1; end
                end else if (flen == 8) begin
                    m_mt = val(fb[1]); m_mo = val(fb[2]); m_st = val(fb[4]); m_so = val(fb[5]);
                    m_dsp = {dig(fb[1], 9), dig(fb[2], 9), dig(fb[4], 9), dig(fb[5], 9)};
                    m_en = (fb[6] == "T") || (fb[6] == "@");
                    m_trig = (fb[6] == "T");
                    m_vld = 1'b1;
                    flen = 0;
                end
            end
        end else if (flen != 0) begin
            idle++;
            if (idle == TO) model_fail();
        end
    endtask

    function automatic logic [31:0] observed();
        return {o_err_cnt, o_AMtens, o_AMones, o_AStens, o_ASones, o_dsp,
                o_alarm_en, o_trig, o_frame_vld, o_err};
    endfunction

    function automatic logic [31:0] expected();
        return {8'(m_cnt), m_mt, m_mo, m_st, m_so, m_dsp, m_en, m_trig, m_vld, m_err};
    endfunction

    function automatic logic [31:0] data_outs();
        return {10'd0, o_AMtens, o_AMones, o_AStens, o_ASones, o_dsp, o_alarm_en, o_trig};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic rdy, input logic [7:0] d);
        rx_data_rdy = rdy;
        rx_data     = d;
        model_step(rdy, d);
        @(posedge clk);
        @(negedge clk);
        if (o_frame_vld) vld_seen++;
        if (o_err) err_seen++;
        chk("cycle", observed(), expected());
    endtask

    task automatic send_bytes(input logic [127:0] b, input int len);
        for (int j = 0; j < len; j++) cycle(1'b1, b[(len - 1 - j) * 8 +: 8]);
    endtask

    task automatic send_random_frame();
        logic [7:0] fr [0:7];
        logic [7:0] flag;
        logic [3:0] mask;
        int r, gap, idx;
        r = $urandom_range(0, 2);
        flag = (r == 0) ? "T" : (r == 1) ? "@" : "-";
        mask = (flag == "-") ? 4'($urandom) : 4'b1111;
        fr[0] = "A";
        fr[1] = mask[3] ? 8'h30 + 8'($urandom_range(0, 5)) : "-";
        fr[2] = mask[2] ? 8'h30 + 8'($urandom_range(0, 9)) : "-";
        fr[3] = mask[2] ? ":" : "-";
        fr[4] = mask[1] ? 8'h30 + 8'($urandom_range(0, 5)) : "-";
        fr[5] = mask[0] ? 8'h30 + 8'($urandom_range(0, 9)) : "-";
        fr[6] = flag;
        fr[7] = CR;
        if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(1, 7);
            fr[idx] = 8'($urandom);
        end
        if ($urandom_range(0, 9) == 0) cycle(1'b1, 8'($urandom));
        for (int j = 0; j < 8; j++) begin
            r = $urandom_range(0, 99);
            gap = (r < 85) ? 0 : (r < 95) ? $urandom_range(1, 5) : $urandom_range(TO - 2, TO + 1);
            repeat (gap) cycle(1'b0, 8'($urandom));
            cycle(1'b1, fr[j]);
        end
    endtask

    initial begin
        tbl[0]  = '{128'({"A12:34@", CR}),      8,  0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 1'b0};
        tbl[1]  = '{128'({"A------", CR}),      8,  0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{128'({"A1-----", CR}),      8,  0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0, 1'b0};
        tbl[3]  = '{128'({"A61:00@", CR}),      8,  1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0, 1'b0};
        tbl[4]  = '{128'({"A05:59T", CR}),      8,  0, 1'b1, 4'd0, 4'd5, 4'd5, 4'd9, 4'b1111, 1'b1, 1'b1};
        tbl[5]  = '{128'({"A12:3A05:00T", CR}), 13, 1, 1'b1, 4'd0, 4'd5, 4'd0, 4'd0, 4'b1111, 1'b1, 1'b1};
        tbl[6]  = '{128'({"A12-34-", CR}),      8,  1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0, 4'b1111, 1'b1, 1'b1};
        tbl[7]  = '{128'({"A-5:-7-", CR}),      8,  0, 1'b1, 4'd0, 4'd5, 4'd0, 4'd7, 4'b0101, 1'b0, 1'b0};
        tbl[8]  = '{128'({"A-5:-7T", CR}),      8,  1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd7, 4'b0101, 1'b0, 1'b0};
        tbl[9]  = '{128'({"A12:34@", 8'h0A}),   8,  1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd7, 4'b0101, 1'b0, 1'b0};
        tbl[10] = '{128'({"A59:09@", CR}),      8,  0, 1'b1, 4'd5, 4'd9, 4'd0, 4'd9, 4'b1111, 1'b1, 1'b0};
        tbl[11] = '{128'({"A--:---", CR}),      8,  1, 1'b0, 4'd5, 4'd9, 4'd0, 4'd9, 4'b1111, 1'b1, 1'b0};
        tbl[12] = '{128'({"A-----T", CR}),      8,  1, 1'b0, 4'd5, 4'd9, 4'd0, 4'd9, 4'b1111, 1'b1, 1'b0};

        rst = 1'b1; rx_data_rdy = 1'b0; rx_data = 8'h00;
        model_reset();
        vld_seen = 0; err_seen = 0; err_total = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", observed(), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NT; i++) begin
            vld_seen = 0; err_seen = 0;
            send_bytes(tbl[i].bytes, tbl[i].len);
            repeat (3) cycle(1'b0, 8'h00);
            err_total += tbl[i].errs;
            chk("tbl_vld", vld_seen, 32'(tbl[i].ok));
            chk("tbl_err", err_seen, tbl[i].errs);
            chk("tbl_cnt", {24'd0, o_err_cnt}, err_total);
            chk("tbl_out", data_outs(), {10'd0, tbl[i].mt, tbl[i].mo, tbl[i].st, tbl[i].so,
                                         tbl[i].dsp, tbl[i].en, tbl[i].trig});
            $display("vector %0d: frames %0d errors %0d err_cnt %0d", i, vld_seen, err_seen, o_err_cnt);
        end

        // Idle after ':' until expiry, then a byte landing exactly on the expiry cycle
        send_bytes(128'("A12:"), 4);
        for (int k = 1; k <= TO + 10; k++) begin
            cycle(1'b0, 8'h00);
            chk("timeout_err", {31'd0, o_err}, (k == TO) ? 32'd1 : 32'd0);
        end
        $display("timeout: expiry after %0d idle cycles, err_cnt %0d", TO, o_err_cnt);
        vld_seen = 0; err_seen = 0;
        send_bytes(128'("A12:"), 4);
        repeat (TO - 1) cycle(1'b0, 8'h00);
        send_bytes(128'({"34@", CR}), 4);
        repeat (2) cycle(1'b0, 8'h00);
        chk("expiry_byte_err", err_seen, 0);
        chk("expiry_byte_vld", vld_seen, 1);
        chk("expiry_byte_out", data_outs(), {10'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 1'b0});
        $display("expiry race: frames %0d errors %0d", vld_seen, err_seen);

        for (int f = 0; f < 200; f++) send_random_frame();
        repeat (TO + 2) cycle(1'b0, 8'h00);
        $display("random: 200 frames, err_cnt %0d", o_err_cnt);

        vld_seen = 0; err_seen = 0;
        for (int f = 0; f < 300; f++) send_bytes(128'("AZ"), 2);
        cycle(1'b0, 8'h00);
        chk("sat_cnt", {24'd0, o_err_cnt}, 32'd255);
        chk("sat_pulses", err_seen, 300);
        $display("saturation: %0d error pulses, err_cnt %0d", err_seen, o_err_cnt);

        send_bytes(128'("A12"), 3);
        rx_data_rdy = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async", observed(), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vld_seen = 0; err_seen = 0;
        send_bytes(128'({"2:34@", CR}), 6);
        chk("post_rst_headless", vld_seen + err_seen, 0);
        send_bytes(128'({"A12:34@", CR}), 8);
        cycle(1'b0, 8'h00);
        chk("post_rst_vld", vld_seen, 1);
        chk("post_rst_out", data_outs(), {10'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 1'b0});
        $display("reset: frames %0d errors %0d after release", vld_seen, err_seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
